// File: rtl/dtm_dmi_master.sv
// dtm_dmi_master: carries one host debug request at a time onto the DMI request/response
// channels. It keeps a sticky error that short-circuits later accesses and aborts a
// transaction whose DMI handshakes do not complete within TIMEOUT cycles.
module dtm_dmi_master #(
  parameter int unsigned ABITS   = 7,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  // Host side
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [1:0]       host_op,
  input  logic [ABITS-1:0] host_addr,
  input  logic [31:0]      host_wdata,
  output logic             host_rsp_valid,
  output logic [31:0]      host_rsp_data,
  output logic [1:0]       host_rsp_status,
  input  logic             dmireset,
  input  logic             dmihardreset,
  // DMI request channel
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [1:0]       dmi_req_op,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  // DMI response channel
  input  logic             dmi_rsp_valid,
  output logic             dmi_rsp_ready,
  input  logic [1:0]       dmi_rsp_op,
  input  logic [31:0]      dmi_rsp_data,
  output logic [1:0]       sticky_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [1:0] StsOk   = 2'd0;
  localparam logic [1:0] StsFail = 2'd2;
  localparam logic [1:0] StsBusy = 2'd3;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [1:0]       sticky_q, sticky_d;

  logic [16:0]      cnt_next;
  logic             timeout_hit;
  logic [1:0]       rsp_sts;
  logic [1:0]       new_err;

  // 17-bit so the comparison cannot wrap when TIMEOUT is 65535.
  assign cnt_next    = {1'b0, cnt_q} + 17'd1;
  assign timeout_hit = cnt_next >= 17'(TIMEOUT);

  // Map DMI response op onto host status; reserved op 1 is reported as failed.
  always_comb begin
    rsp_sts = StsFail;
    unique case (dmi_rsp_op)
      2'd0:    rsp_sts = StsOk;
      2'd3:    rsp_sts = StsBusy;
      default: rsp_sts = StsFail;
    endcase
  end

  // Next-state, datapath capture and handshake outputs.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    rsp_data_d     = rsp_data_q;
    rsp_status_d   = rsp_status_q;
    new_err        = StsOk;
    host_ready     = 1'b0;
    host_rsp_valid = 1'b0;
    dmi_req_valid  = 1'b0;
    dmi_rsp_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        host_ready = 1'b1;
        if (host_valid) begin
          if ((host_op == OpRead || host_op == OpWrite) && sticky_q == StsOk) begin
            op_d    = host_op;
            addr_d  = host_addr;
            wdata_d = (host_op == OpWrite) ? host_wdata : 32'd0;
            cnt_d   = '0;
            state_d = StReq;
          end else begin
            // nop/reserved, or access blocked by a pending sticky error
            rsp_data_d   = '0;
            rsp_status_d = sticky_q;
            state_d      = StDone;
          end
        end
      end
      StReq: begin
        dmi_req_valid = 1'b1;
        cnt_d         = cnt_next[15:0];
        if (dmi_req_ready) begin
          state_d = StWait;
        end else if (timeout_hit) begin
          rsp_data_d   = '0;
          rsp_status_d = StsBusy;
          new_err      = StsBusy;
          state_d      = StDone;
        end
      end
      StWait: begin
        dmi_rsp_ready = 1'b1;
        cnt_d         = cnt_next[15:0];
        if (dmi_rsp_valid) begin
          rsp_status_d = rsp_sts;
          rsp_data_d   = (op_q == OpRead && dmi_rsp_op == 2'd0) ? dmi_rsp_data : 32'd0;
          new_err      = rsp_sts;
          state_d      = StDone;
        end else if (timeout_hit) begin
          rsp_data_d   = '0;
          rsp_status_d = StsBusy;
          new_err      = StsBusy;
          state_d      = StDone;
        end
      end
      StDone: begin
        host_rsp_valid = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Busy dominates failed; dmireset dominates any new error.
    sticky_d = sticky_q;
    if (new_err == StsBusy) begin
      sticky_d = StsBusy;
    end else if (new_err == StsFail && sticky_q != StsBusy) begin
      sticky_d = StsFail;
    end
    if (dmireset) begin
      sticky_d = StsOk;
    end
  end

  // State register; dmihardreset acts exactly like a synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n || dmihardreset) begin
      state_q      <= StIdle;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      sticky_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      sticky_q     <= sticky_d;
    end
  end

  assign host_rsp_data   = rsp_data_q;
  assign host_rsp_status = rsp_status_q;
  assign dmi_req_op      = op_q;
  assign dmi_req_addr    = addr_q;
  assign dmi_req_data    = wdata_q;
  assign sticky_err      = sticky_q;

endmodule

// File: tb/tb_dtm_dmi_master.sv
// Scoreboard bench for dtm_dmi_master: the host driver predicts each response from
// transaction-level rules and queues it; a monitor pops and compares on host_rsp_valid.
// A DMI responder plays back a per-transaction wait/response plan.
module tb_dtm_dmi_master;

  localparam int unsigned TMO = 8;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  status;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    int          req_wait;
    int          rsp_wait;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_data;
  } plan_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_valid;
  logic        host_ready;
  logic [1:0]  host_op;
  logic [6:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_rsp_valid;
  logic [31:0] host_rsp_data;
  logic [1:0]  host_rsp_status;
  logic        dmireset;
  logic        dmihardreset;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [1:0]  dmi_req_op;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic        dmi_rsp_valid;
  logic        dmi_rsp_ready;
  logic [1:0]  dmi_rsp_op;
  logic [31:0] dmi_rsp_data;
  logic [1:0]  sticky_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_count = 0;
  bit force_rsp = 1'b0;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  // Reference state
  logic [1:0]  sticky_m = 2'd0;
  logic [31:0] last_data = 32'd0;
  logic [1:0]  last_status = 2'd0;

  dtm_dmi_master #(
    .ABITS  (7),
    .TIMEOUT(TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_op        (host_op),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_data  (host_rsp_data),
    .host_rsp_status(host_rsp_status),
    .dmireset       (dmireset),
    .dmihardreset   (dmihardreset),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_op     (dmi_req_op),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_data   (dmi_req_data),
    .dmi_rsp_valid  (dmi_rsp_valid),
    .dmi_rsp_ready  (dmi_rsp_ready),
    .dmi_rsp_op     (dmi_rsp_op),
    .dmi_rsp_data   (dmi_rsp_data),
    .sticky_err     (sticky_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [1:0] status_of(input logic [1:0] rsp_op);
    if (rsp_op == 2'd0) return 2'd0;
    if (rsp_op == 2'd3) return 2'd3;
    return 2'd2;
  endfunction

  // Monitor: every response pulse must match the oldest prediction, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (host_rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_host_rsp");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", host_rsp_data, e.data);
          chk("rsp_status", {30'd0, host_rsp_status}, {30'd0, e.status});
          chk("rsp_cycle", cyc, e.cyc);
        end
        rsp_count++;
      end
    end
  end

  // DMI responder: follows the next plan whenever a new request appears.
  initial begin
    plan_t cur;
    bit req_ph = 1'b0;
    bit rsp_ph = 1'b0;
    bit bogus = 1'b0;
    int n = 0;
    dmi_req_ready = 1'b0;
    dmi_rsp_valid = 1'b0;
    dmi_rsp_op    = 2'd0;
    dmi_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      dmi_req_ready = 1'b0;
      dmi_rsp_valid = force_rsp;
      dmi_rsp_op    = 2'($urandom);
      dmi_rsp_data  = $urandom;
      if (rsp_ph && dmi_rsp_ready !== 1'b1) rsp_ph = 1'b0;
      if (rsp_ph) begin
        if (n == cur.rsp_wait) begin
          dmi_rsp_valid = 1'b1;
          dmi_rsp_op    = cur.rsp_op;
          dmi_rsp_data  = cur.rsp_data;
          rsp_ph        = 1'b0;
        end
        n++;
      end
      if (dmi_req_valid === 1'b1) begin
        if (!req_ph) begin
          req_ph = 1'b1;
          n      = 0;
          bogus  = (plan_q.size() == 0);
          if (bogus) flag("unexpected_dmi_req");
          else cur = plan_q.pop_front();
        end
        if (!bogus) begin
          chk("dmi_req_op", {30'd0, dmi_req_op}, {30'd0, cur.op});
          chk("dmi_req_addr", {25'd0, dmi_req_addr}, {25'd0, cur.addr});
          chk("dmi_req_data", dmi_req_data, cur.data);
          if (n == cur.req_wait) begin
            dmi_req_ready = 1'b1;
            req_ph        = 1'b0;
            rsp_ph        = 1'b1;
            n             = 0;
          end else begin
            n++;
          end
        end
      end else begin
        req_ph = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (host_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (host_ready !== 1'b1) flag("host_ready_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_host_ready"}, {31'd0, host_ready}, 32'd1);
    chk({tag, "_host_rsp_valid"}, {31'd0, host_rsp_valid}, 32'd0);
    chk({tag, "_host_rsp_data"}, host_rsp_data, 32'd0);
    chk({tag, "_host_rsp_status"}, {30'd0, host_rsp_status}, 32'd0);
    chk({tag, "_dmi_req_valid"}, {31'd0, dmi_req_valid}, 32'd0);
    chk({tag, "_dmi_rsp_ready"}, {31'd0, dmi_rsp_ready}, 32'd0);
    chk({tag, "_dmi_req_op"}, {30'd0, dmi_req_op}, 32'd0);
    chk({tag, "_dmi_req_addr"}, {25'd0, dmi_req_addr}, 32'd0);
    chk({tag, "_dmi_req_data"}, dmi_req_data, 32'd0);
    chk({tag, "_sticky_err"}, {30'd0, sticky_err}, 32'd0);
  endtask

  // One host transaction. Expected result follows the transaction-level rules: no DMI
  // traffic for nop/reserved or while sticky is set; otherwise the request/response waits
  // must fit in TMO cycles in total, else the access is busy after TMO+1 cycles.
  task automatic txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                     input int req_wait, input int rsp_wait, input logic [1:0] rsp_op,
                     input logic [31:0] rsp_data, input bit dmireset_at_rsp);
    exp_t  e;
    plan_t p;
    int    start;
    int    k;
    wait_ready();
    chk("hold_rsp_data", host_rsp_data, last_data);
    chk("hold_rsp_status", {30'd0, host_rsp_status}, {30'd0, last_status});
    host_valid = 1'b1;
    host_op    = op;
    host_addr  = addr;
    host_wdata = wdata;
    e.data   = 32'd0;
    e.status = sticky_m;
    e.cyc    = cyc + 1;
    if ((op == 2'd1 || op == 2'd2) && sticky_m == 2'd0) begin
      p.op       = op;
      p.addr     = addr;
      p.data     = (op == 2'd2) ? wdata : 32'd0;
      p.req_wait = req_wait;
      p.rsp_wait = rsp_wait;
      p.rsp_op   = rsp_op;
      p.rsp_data = rsp_data;
      plan_q.push_back(p);
      if (req_wait + rsp_wait + 2 > int'(TMO)) begin
        e.status = 2'd3;
        e.cyc    = cyc + int'(TMO) + 1;
      end else begin
        e.status = status_of(rsp_op);
        e.data   = (op == 2'd1 && rsp_op == 2'd0) ? rsp_data : 32'd0;
        e.cyc    = cyc + req_wait + rsp_wait + 3;
      end
      if (dmireset_at_rsp) sticky_m = 2'd0;
      else if (e.status == 2'd3) sticky_m = 2'd3;
      else if (e.status == 2'd2 && sticky_m != 2'd3) sticky_m = 2'd2;
    end
    exp_q.push_back(e);
    last_data   = e.data;
    last_status = e.status;
    start       = rsp_count;
    @(negedge clk);
    host_valid = 1'b0;
    host_op    = 2'($urandom);
    host_wdata = $urandom;
    if (dmireset_at_rsp) begin
      @(negedge clk);
      dmireset = 1'b1;
      @(negedge clk);
      dmireset = 1'b0;
    end
    k = 0;
    while (rsp_count == start && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (rsp_count == start) flag("host_rsp_timeout");
    chk("sticky_err", {30'd0, sticky_err}, {30'd0, sticky_m});
  endtask

  task automatic pulse_dmireset();
    dmireset = 1'b1;
    @(negedge clk);
    dmireset = 1'b0;
    sticky_m = 2'd0;
    chk("dmireset_sticky", {30'd0, sticky_err}, 32'd0);
  endtask

  initial begin
    int start;
    int rw;
    rst_n        = 1'b0;
    host_valid   = 1'b0;
    host_op      = 2'd0;
    host_addr    = 7'd0;
    host_wdata   = 32'd0;
    dmireset     = 1'b0;
    dmihardreset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait write, then a read with a 5-cycle response wait.
    txn(2'd2, 7'h10, 32'h0000_0001, 0, 0, 2'd0, 32'd0, 1'b0);
    txn(2'd1, 7'h11, 32'hDEAD_BEEF, 0, 5, 2'd0, 32'h0040_0C82, 1'b0);

    // Busy response sets sticky; next write is short-circuited until dmireset.
    txn(2'd1, 7'h12, 32'd0, 1, 0, 2'd3, 32'h1234_5678, 1'b0);
    txn(2'd2, 7'h13, 32'hCAFE_F00D, 0, 0, 2'd0, 32'd0, 1'b0);
    txn(2'd0, 7'h14, 32'd0, 0, 0, 2'd0, 32'd0, 1'b0);
    pulse_dmireset();
    txn(2'd1, 7'h15, 32'd0, 0, 0, 2'd0, 32'hA5A5_5A5A, 1'b0);

    // Request channel stalled past TIMEOUT.
    txn(2'd1, 7'h16, 32'd0, 30, 0, 2'd0, 32'd0, 1'b0);

    // Hardreset while idle with sticky busy clears everything.
    dmihardreset = 1'b1;
    @(negedge clk);
    dmihardreset = 1'b0;
    sticky_m    = 2'd0;
    last_data   = 32'd0;
    last_status = 2'd0;
    check_reset_outputs("hardreset_idle");

    // Failed and reserved responses; dmireset coincident with a failed response wins.
    txn(2'd1, 7'h17, 32'd0, 0, 0, 2'd2, 32'h1111_2222, 1'b1);
    txn(2'd2, 7'h18, 32'h3333_4444, 0, 0, 2'd1, 32'd0, 1'b0);
    txn(2'd3, 7'h19, 32'd0, 0, 0, 2'd0, 32'd0, 1'b0);
    pulse_dmireset();

    // Timeout boundary: total waits filling TMO exactly complete, one more times out.
    txn(2'd1, 7'h1A, 32'd0, 3, 3, 2'd0, 32'h0BAD_CAFE, 1'b0);
    txn(2'd1, 7'h1B, 32'd0, 3, 4, 2'd0, 32'h0BAD_CAFE, 1'b0);
    pulse_dmireset();

    // Reset while waiting for the DMI response: no host response, later rsp ignored.
    wait_ready();
    host_valid = 1'b1;
    host_op    = 2'd1;
    host_addr  = 7'h22;
    plan_q.push_back('{2'd1, 7'h22, 32'd0, 0, 6, 2'd0, 32'h7777_7777});
    @(negedge clk);
    host_valid = 1'b0;
    @(negedge clk);
    chk("wait_entered", {31'd0, dmi_rsp_ready}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    sticky_m    = 2'd0;
    last_data   = 32'd0;
    last_status = 2'd0;
    check_reset_outputs("reset_in_wait");
    start     = rsp_count;
    force_rsp = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rsp_ready_after_reset", {31'd0, dmi_rsp_ready}, 32'd0);
    end
    force_rsp = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_rsp_after_reset", rsp_count, start);

    // Hardreset during a stalled request abandons it silently.
    wait_ready();
    host_valid = 1'b1;
    host_op    = 2'd2;
    host_addr  = 7'h33;
    host_wdata = 32'h5555_AAAA;
    plan_q.push_back('{2'd2, 7'h33, 32'h5555_AAAA, 30, 0, 2'd0, 32'd0});
    start = rsp_count;
    @(negedge clk);
    host_valid = 1'b0;
    @(negedge clk);
    dmihardreset = 1'b1;
    @(negedge clk);
    dmihardreset = 1'b0;
    check_reset_outputs("hardreset_in_req");
    repeat (12) @(negedge clk);
    chk("no_rsp_after_hardreset", rsp_count, start);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      if ((sticky_m != 2'd0 && $urandom_range(0, 9) < 4) || $urandom_range(0, 19) == 0) begin
        pulse_dmireset();
      end
      rw = ($urandom_range(0, 9) == 0) ? int'(TMO) + $urandom_range(0, 2)
                                         : $urandom_range(0, TMO - 2);
      txn(2'($urandom), 7'($urandom), $urandom, rw, $urandom_range(0, 7),
          ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0, $urandom, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("plan_q_drained", plan_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL global_time_limit (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule
